mips_register_file: RTL and testbench

- 32-entry general-purpose register file for the MIPS datapath.
- Sits directly upstream of the ALU: supplies operand a (rs) and operand b (rt). Accepts writeback from the ALU/memory result path.
- Two combinational read ports and one synchronous write port.
- Register $zero is hardwired to 0. A same-cycle write is bypassed to the read ports so a decode-stage read sees the writeback value.

---
 rtl/mips_register_file_if.sv | 34 +++
 rtl/mips_register_file.sv | 64 ++++++
 tb/tb_mips_register_file.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_register_file_if.sv
// Read/write bus of the MIPS register file: two read ports, one write port.
// The datapath drives indices and writeback (master); the register file answers (slave).
interface mips_register_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1,
    output read_reg2,
    output write_reg,
    output write_data,
    output reg_write,
    input  read_data1,
    input  read_data2
  );

  modport slave (
    input  read_reg1,
    input  read_reg2,
    input  write_reg,
    input  write_data,
    input  reg_write,
    output read_data1,
    output read_data2
  );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: $zero hardwired, two combinational read ports with
// same-cycle write bypass, one synchronous write port, synchronous active-low reset.
module mips_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  mips_register_file_if.slave rf
);

  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : gen_bad_cfg
    $error("NUM_REGS must equal 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_en;

  // Writes to $zero are dropped here, so entry 0 stays 0 from reset onwards.
  assign wr_en = rst_n && rf.reg_write && (rf.write_reg != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rf.write_reg] = rf.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets a decode-stage read observe the writeback of the same cycle.
  always_comb begin
    rf.read_data1 = '0;
    if (rst_n && (rf.read_reg1 != '0)) begin
      if (wr_en && (rf.write_reg == rf.read_reg1)) begin
        rf.read_data1 = rf.write_data;
      end else begin
        rf.read_data1 = regs_q[rf.read_reg1];
      end
    end
  end

  always_comb begin
    rf.read_data2 = '0;
    if (rst_n && (rf.read_reg2 != '0)) begin
      if (wr_en && (rf.write_reg == rf.read_reg2)) begin
        rf.read_data2 = rf.write_data;
      end else begin
        rf.read_data2 = regs_q[rf.read_reg2];
      end
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: expectations are queued when a cycle is
// driven and compared against both read ports mid-cycle.
module tb_mips_register_file;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] model_q [32];
  string       tag_q [$];
  logic [31:0] exp1_q [$];
  logic [31:0] exp2_q [$];

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  mips_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf   (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic rst, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd,
                                             input logic [4:0] r);
    if (r == 5'd0 || !rst) return 32'h0;
    if (we && wr == r) return wd;
    return model_q[r];
  endfunction

  // One clock cycle: drive, queue expectations, sample/compare, then commit the model.
  task automatic cycle(input string tag, input logic rst, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst_n            = rst;
    rf_if.reg_write  = we;
    rf_if.write_reg  = wr;
    rf_if.write_data = wd;
    rf_if.read_reg1  = r1;
    rf_if.read_reg2  = r2;
    tag_q.push_back(tag);
    exp1_q.push_back(model_read(rst, we, wr, wd, r1));
    exp2_q.push_back(model_read(rst, we, wr, wd, r2));
    #1;
    begin
      string       t;
      logic [31:0] e1;
      logic [31:0] e2;
      t  = tag_q.pop_front();
      e1 = exp1_q.pop_front();
      e2 = exp2_q.pop_front();
      check({t, "_rd1"}, rf_if.read_data1, e1);
      check({t, "_rd2"}, rf_if.read_data2, e2);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) model_q[i] = 32'h0;
    end else if (we && wr != 5'd0) begin
      model_q[wr] = wd;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) model_q[i] = 32'h0;
    rst_n            = 1'b0;
    rf_if.reg_write  = 1'b0;
    rf_if.write_reg  = '0;
    rf_if.write_data = '0;
    rf_if.read_reg1  = '0;
    rf_if.read_reg2  = '0;

    // Reset with a write pending: outputs stay 0, write discarded
    cycle("rst0", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    cycle("rst1", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    cycle("rst_rel", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    cycle("rst_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);

    // Basic write/read
    cycle("wr8", 1'b1, 1'b1, 5'd8, 32'h00000004, 5'd0, 5'd0);
    cycle("wr9", 1'b1, 1'b1, 5'd9, 32'h00000001, 5'd8, 5'd0);
    cycle("rd89", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);

    // $zero
    cycle("zero_wr", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle("zero_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Bypass
    cycle("r10_init", 1'b1, 1'b1, 5'd10, 32'h11111111, 5'd0, 5'd0);
    cycle("r10_nowe", 1'b1, 1'b0, 5'd10, 32'h22222222, 5'd10, 5'd10);
    cycle("r10_byp", 1'b1, 1'b1, 5'd10, 32'h22222222, 5'd10, 5'd10);
    cycle("r10_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
    cycle("byp_xy", 1'b1, 1'b1, 5'd10, 32'h33333333, 5'd10, 5'd8);

    // Back-to-back writes: each visible via bypass, last wins
    cycle("b2b_a", 1'b1, 1'b1, 5'd12, 32'h0000AAAA, 5'd12, 5'd0);
    cycle("b2b_b", 1'b1, 1'b1, 5'd12, 32'h0000BBBB, 5'd12, 5'd12);
    cycle("b2b_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd10);

    // Reset mid-operation
    cycle("r31_wr", 1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd31);
    cycle("r31_rst", 1'b0, 1'b1, 5'd31, 32'h5A5A5A5A, 5'd31, 5'd31);
    cycle("r31_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd31);

    // Sweep
    for (int i = 1; i < 32; i++) begin
      cycle("sweep_wr", 1'b1, 1'b1, 5'(i), 32'(i * 3), 5'(i), 5'(i - 1));
    end
    for (int i = 1; i < 32; i++) begin
      cycle("sweep_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
    end
    cycle("sweep_zero", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Literal spot checks independent of the model
    @(negedge clk);
    rf_if.reg_write = 1'b0;
    rf_if.read_reg1 = 5'd7;
    rf_if.read_reg2 = 5'd25;
    #1;
    check("lit_r7", rf_if.read_data1, 32'd21);
    check("lit_r25", rf_if.read_data2, 32'd75);
    check("sb_empty", 32'(tag_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
